uart_dte_rx_fifo: RTL
=====================

Name: uart_dte_rx_fifo

Overview:
Serial receive stage downstream of the dual-core system's UART DTE port. It samples the system's TXD line, deserializes 8N1 frames and buffers received bytes in a small FIFO. The FIFO drains through a valid/ready byte stream consumed by the host-side bridge or the bench scoreboard. It also reports framing errors and FIFO overflow as sticky flags.

Parameters:
CLKS_PER_BIT, 868, clk_i cycles per UART bit (100 MHz / 115200); must be >= 4
FIFO_DEPTH, 4, byte FIFO entries; power of 2, >= 2
CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count_o

Ports:
clk_i  input  1  system clock
rstn_i  input  1  asynchronous active-low reset
rxd_i  input  1  serial line from the system UART TXD; asynchronous; idles high
rx_data_o  output  8  byte at FIFO head
rx_valid_o  output  1  FIFO non-empty; rx_data_o is valid
rx_ready_i  input  1  consumer accepts head byte when rx_valid_o=1
fifo_count_o  output  CNT_W  bytes currently held
frame_err_o  output  1  sticky: stop bit sampled low
overflow_o  output  1  sticky: byte completed while FIFO full
clr_err_i  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset is asynchronous and active-low; there is one clock. Reset mid-frame aborts the frame, empties the FIFO and returns the FSM to IDLE.
- All outputs are 0 in reset: rx_data_o=0, rx_valid_o=0, fifo_count_o=0, frame_err_o=0, overflow_o=0. The synchronizer flops reset to 1 (line idle).
- rxd_i passes through a 2-FF synchronizer; the FSM uses the synchronized value rxd_s.
- IDLE: on rxd_s=0, load bit_cnt_clk=CLKS_PER_BIT/2-1 and go to START.
- START: on reaching zero, if rxd_s=0 go to DATA with bit_idx=0 and the counter at CLKS_PER_BIT-1. Otherwise the start was a glitch: return to IDLE and record no error.
- DATA: each time the counter expires, shift rxd_s into shreg LSB-first and reload CLKS_PER_BIT-1. After bit_idx 7, go to STOP.
- STOP: when the counter expires, sample rxd_s.
  - If rxd_s=1 and the FIFO is not full: push shreg.
  - If rxd_s=1 and the FIFO is full: drop the byte and set overflow_o.
  - If rxd_s=0: drop the byte and set frame_err_o.
  - In all cases go to IDLE. If rxd_s=0, IDLE waits for rxd_s=1 before it re-arms the start detect, so a break produces only one error.
- Push-to-visibility latency: the byte is on rx_data_o with rx_valid_o=1 on the cycle after the stop-bit sample.
- Pop: a byte is popped when rx_valid_o & rx_ready_i at a rising edge. rx_data_o shows the next entry on the following cycle.
  - rx_data_o is don't-care when rx_valid_o=0, but it must not change while rx_valid_o=1 and rx_ready_i=0.
- Simultaneous push and pop:
  - FIFO full: the pop frees space first, the push succeeds, count stays FIFO_DEPTH and no overflow is flagged.
  - FIFO empty: no pop occurs because rx_valid_o=0.
- The FIFO uses read/write pointers one bit wider than log2(FIFO_DEPTH) and wraps modulo 2*FIFO_DEPTH. fifo_count_o = wptr - rptr.
- Sticky flags:
  - They are set on the cycle after the triggering sample and hold until clr_err_i=1.
  - If a set event and clr_err_i occur on the same cycle, set wins.
- Counters and FSM ignore rx_ready_i. Reception never stalls, and overflow is the only back-pressure indication.

Test Plan:
- CLKS_PER_BIT=8, FIFO_DEPTH=4; send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with rx_ready_i=0 -> rx_valid_o=1, rx_data_o=0xA5 and fifo_count_o=1 one cycle after the stop sample; both flags 0.
- Send 0x01, 0x80, 0xFF, 0x00 back-to-back, then assert rx_ready_i -> four pops in order 0x01, 0x80, 0xFF, 0x00; count goes 4,3,2,1,0; rx_valid_o=0 after the last pop.
- Fill 4 bytes with rx_ready_i=0, then send 0x3C -> overflow_o=1, count=4, head still first byte. Then pulse clr_err_i -> overflow_o=0.
- Frame 0x55 with stop bit driven 0, then line high -> frame_err_o=1, count unchanged. A following valid 0x12 is received normally.
- Drive a 2-cycle low glitch on rxd_i (< CLKS_PER_BIT/2) -> FSM returns to IDLE, no byte, no flags.
- Assert rstn_i=0 mid-DATA with 2 bytes queued -> all outputs 0 immediately. After release, a fresh 0x7E is received correctly as the only entry.

Source files
------------

// File: rtl/uart_dte_rx_fifo.sv
// UART 8N1 receiver with a small byte FIFO drained over a valid/ready stream.
// Latency: the byte is visible on rx_data_o/rx_valid_o the cycle after the stop-bit sample.
// Backpressure: reception never stalls; a byte completing into a full FIFO is dropped and flagged.
//
// Ports:
//   clk_i, rstn_i           clock, async active-low reset
//   rxd_i                   asynchronous serial input, idles high
//   rx_data_o/rx_valid_o    FIFO head byte / FIFO non-empty
//   rx_ready_i              consumer pops the head when rx_valid_o=1
//   fifo_count_o            bytes currently held
//   frame_err_o/overflow_o  sticky error flags, cleared by clr_err_i
module uart_dte_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             rxd_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic [CNT_W-1:0] fifo_count_o,
    output logic             frame_err_o,
    output logic             overflow_o,
    input  logic             clr_err_i
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] HALF_M1 = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] FULL_M1 = BCW'(CLKS_PER_BIT - 1);

    // ST_BREAK holds off start detection after a low stop bit until the line
    // returns high, so a held-low line reports a single framing error.
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

    state_t          state_q, state_d;
    logic            rxd_meta_q, rxd_s_q;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic            ferr_q, ferr_d, ovf_q, ovf_d;
    logic            cnt_zero, stop_ok, stop_bad;
    logic            full, pop, push, ovf_set;

    assign cnt_zero = (bit_cnt_q == '0);

    // ---------------- state register + datapath flops ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_s_q    <= rxd_meta_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rxd_s_q) state_d = ST_START;
            ST_START: if (cnt_zero) state_d = rxd_s_q ? ST_IDLE : ST_DATA;
            ST_DATA:  if (cnt_zero && bit_idx_q == 3'd7) state_d = ST_STOP;
            ST_STOP:  if (cnt_zero) state_d = rxd_s_q ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxd_s_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- per-state outputs: bit timing, shift, stop verdict ----------------
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s_q) bit_cnt_d = HALF_M1;
            end
            ST_START: begin
                if (cnt_zero) begin
                    bit_cnt_d = FULL_M1;
                    bit_idx_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_zero) begin
                    shreg_d   = {rxd_s_q, shreg_q[7:1]};
                    bit_cnt_d = FULL_M1;
                    bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_zero) begin
                    stop_ok  = rxd_s_q;
                    stop_bad = !rxd_s_q;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- FIFO ----------------
    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rx_valid_o = (wptr_q != rptr_q);
    assign pop        = rx_valid_o & rx_ready_i;
    // A same-cycle pop frees the slot, so a full FIFO can still accept the byte.
    assign push       = stop_ok && (!full || pop);
    assign ovf_set    = stop_ok && full && !pop;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = shreg_q;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
    end

    // Set has priority over clear.
    always_comb begin
        ferr_d = stop_bad ? 1'b1 : (clr_err_i ? 1'b0 : ferr_q);
        ovf_d  = ovf_set  ? 1'b1 : (clr_err_i ? 1'b0 : ovf_q);
    end

    assign rx_data_o    = mem_q[rptr_q[AW-1:0]];
    assign fifo_count_o = CNT_W'(wptr_q - rptr_q);
    assign frame_err_o  = ferr_q;
    assign overflow_o   = ovf_q;

endmodule
